// File: rtl/spi_lcd_reg_reader.sv
// rtl/spi_lcd_reg_reader.sv - 3-wire SPI LCD register read engine (command, dummy, turnaround, capture)
module spi_lcd_reg_reader #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic [5:0]  rd_bits,
    input  logic [1:0]  dummy_clks,
    output logic        LCD_CSX,
    output logic        LCD_DC,
    output logic        LCD_SCK,
    output logic        LCD_SDA_out,
    output logic        SDA_Read,
    input  logic        LCD_SDA_in,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy
);

    localparam int DIV_W = (CLK_DIV  < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam int SET_W = (CS_SETUP < 1) ? 1 : $clog2(CS_SETUP + 1);
    localparam int HLD_W = (CS_HOLD  < 1) ? 1 : $clog2(CS_HOLD + 1);
    localparam int TMR_W = (SET_W > HLD_W) ? SET_W : HLD_W;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       state_q,    state_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [TMR_W-1:0] tmr_q,      tmr_d;
    logic [5:0]       bit_q,      bit_d;
    logic [6:0]       cmd_sh_q,   cmd_sh_d;
    logic [5:0]       rd_bits_q,  rd_bits_d;
    logic [1:0]       dummy_q,    dummy_d;
    logic [31:0]      shreg_q,    shreg_d;
    logic [31:0]      rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             csx_q,      csx_d;
    logic             sck_q,      sck_d;
    logic             sda_out_q,  sda_out_d;
    logic             sda_read_q, sda_read_d;

    logic        slot_end;
    logic        in_slot;
    logic [5:0]  rd_clamped;
    logic [31:0] rd_mask;

    always_comb begin
        rd_clamped = (rd_bits > 6'd32) ? 6'd32 : rd_bits;
    end

    always_comb begin
        if (rd_bits_q >= 6'd32) begin
            rd_mask = 32'hFFFF_FFFF;
        end else begin
            rd_mask = (32'd1 << rd_bits_q) - 32'd1;
        end
    end

    assign in_slot = (state_q == S_CMD) || (state_q == S_DUMMY) || (state_q == S_READ);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tmr_d      = tmr_q;
        bit_d      = bit_q;
        cmd_sh_d   = cmd_sh_q;
        rd_bits_d  = rd_bits_q;
        dummy_d    = dummy_q;
        shreg_d    = shreg_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        csx_d      = csx_q;
        sck_d      = sck_q;
        sda_out_d  = sda_out_q;
        sda_read_d = sda_read_q;
        slot_end   = 1'b0;

        // One bit slot = CLK_DIV cycles low then CLK_DIV cycles high; the slot ends on the falling edge.
        if (in_slot) begin
            if (div_q != DIV_LAST) begin
                div_d = div_q + DIV_W'(1);
            end else begin
                div_d    = '0;
                sck_d    = ~sck_q;
                slot_end = sck_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d    = S_SETUP;
                    cmd_sh_d   = cmd_byte[6:0];
                    rd_bits_d  = rd_clamped;
                    dummy_d    = dummy_clks;
                    csx_d      = 1'b0;
                    sck_d      = 1'b0;
                    sda_out_d  = cmd_byte[7];
                    sda_read_d = 1'b0;
                    tmr_d      = '0;
                    div_d      = '0;
                    bit_d      = '0;
                    shreg_d    = '0;
                end
            end
            S_SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    state_d = S_CMD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_CMD: begin
                if (slot_end) begin
                    bit_d     = bit_q + 6'd1;
                    sda_out_d = cmd_sh_q[6];
                    cmd_sh_d  = {cmd_sh_q[5:0], 1'b0};
                    if (bit_q == 6'd7) begin
                        bit_d     = '0;
                        sda_out_d = 1'b0;
                        if (dummy_q != 2'd0) begin
                            state_d    = S_DUMMY;
                            sda_read_d = 1'b1;
                        end else if (rd_bits_q != 6'd0) begin
                            state_d    = S_READ;
                            sda_read_d = 1'b1;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_DUMMY: begin
                if (slot_end) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == {4'd0, dummy_q} - 6'd1) begin
                        bit_d   = '0;
                        state_d = (rd_bits_q != 6'd0) ? S_READ : S_HOLD;
                    end
                end
            end
            S_READ: begin
                // Sample on the edge that ends the high phase, i.e. together with the SCK fall.
                if (slot_end) begin
                    shreg_d = {shreg_q[30:0], LCD_SDA_in};
                    bit_d   = bit_q + 6'd1;
                    if (bit_q == rd_bits_q - 6'd1) begin
                        bit_d   = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_d    = S_DONE;
                    tmr_d      = '0;
                    csx_d      = 1'b1;
                    sda_read_d = 1'b0;
                    rd_data_d  = shreg_q & rd_mask;
                    rd_valid_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                csx_d      = 1'b1;
                sck_d      = 1'b0;
                sda_out_d  = 1'b0;
                sda_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            tmr_q      <= '0;
            bit_q      <= '0;
            cmd_sh_q   <= '0;
            rd_bits_q  <= '0;
            dummy_q    <= '0;
            shreg_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            csx_q      <= 1'b1;
            sck_q      <= 1'b0;
            sda_out_q  <= 1'b0;
            sda_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            cmd_sh_q   <= cmd_sh_d;
            rd_bits_q  <= rd_bits_d;
            dummy_q    <= dummy_d;
            shreg_q    <= shreg_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            csx_q      <= csx_d;
            sck_q      <= sck_d;
            sda_out_q  <= sda_out_d;
            sda_read_q <= sda_read_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = ~cmd_ready;
    assign LCD_CSX     = csx_q;
    assign LCD_DC      = 1'b0;
    assign LCD_SCK     = sck_q;
    assign LCD_SDA_out = sda_out_q;
    assign SDA_Read    = sda_read_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_spi_lcd_reg_reader.sv
// tb/tb_spi_lcd_reg_reader.sv - bench for spi_lcd_reg_reader with SPI slave model and reference checks
module tb_spi_lcd_reg_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [7:0]  cmd_byte  [2];
    logic [5:0]  rd_bits   [2];
    logic [1:0]  dummy_clks[2];
    logic        csx [2];
    logic        dc  [2];
    logic        sck [2];
    logic        sda_out [2];
    logic        sda_read[2];
    logic        sda_in  [2];
    logic [31:0] rd_data [2];
    logic        rd_valid[2];
    logic        busy    [2];

    int          rises  [2] = '{0, 0};
    int          falls  [2] = '{0, 0};
    int          err_cnt[2] = '{0, 0};
    int          vcnt   [2] = '{0, 0};
    int          gap_min[2] = '{1000, 1000};
    int          gap_run[2] = '{0, 0};
    logic [7:0]  cmd_cap[2];
    logic [63:0] resp   [2];
    int          d_exp  [2];
    int          n_exp  [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_lcd_reg_reader #(.CLK_DIV(g == 0 ? 4 : 1), .CS_SETUP(2), .CS_HOLD(2)) dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_byte(cmd_byte[g]), .rd_bits(rd_bits[g]), .dummy_clks(dummy_clks[g]),
            .LCD_CSX(csx[g]), .LCD_DC(dc[g]), .LCD_SCK(sck[g]),
            .LCD_SDA_out(sda_out[g]), .SDA_Read(sda_read[g]), .LCD_SDA_in(sda_in[g]),
            .rd_data(rd_data[g]), .rd_valid(rd_valid[g]), .busy(busy[g])
        );

        // Slave model: latches command bits on SCK rise, presents response bits for each read slot.
        logic sck_prev = 1'b0;
        logic csx_prev = 1'b1;
        int   k;
        always @(negedge clk) begin
            if (csx_prev && !csx[g]) begin
                rises[g] = 0;
                falls[g] = 0;
                if (gap_run[g] < gap_min[g]) gap_min[g] = gap_run[g];
            end
            if (csx[g]) gap_run[g] = gap_run[g] + 1;
            else gap_run[g] = 0;
            if (sck[g] && !sck_prev) begin
                if (sda_read[g] !== (rises[g] >= 8)) err_cnt[g] = err_cnt[g] + 1;
                if (rises[g] < 8) cmd_cap[g] = {cmd_cap[g][6:0], sda_out[g]};
                if (rises[g] >= 8 + d_exp[g]) begin
                    k = rises[g] - 8 - d_exp[g];
                    sda_in[g] = (k < 64) ? resp[g][63 - k] : 1'b0;
                end else begin
                    sda_in[g] = 1'($urandom);
                end
                rises[g] = rises[g] + 1;
            end
            if (!sck[g] && sck_prev) begin
                falls[g] = falls[g] + 1;
                if (falls[g] == 8 && sda_read[g] !== ((d_exp[g] + n_exp[g]) > 0))
                    err_cnt[g] = err_cnt[g] + 1;
            end
            if (rd_valid[g]) vcnt[g] = vcnt[g] + 1;
            sck_prev = sck[g];
            csx_prev = csx[g];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [63:0] r, input int n);
        return (n == 0) ? 32'h0 : 32'(r >> (64 - n));
    endfunction

    task automatic xfer(input int g, input logic [7:0] c, input int rd, input int dm,
                        input logic [63:0] r, input string tag);
        int n, e0, v0, to;
        n = (rd > 32) ? 32 : rd;
        resp[g] = r; d_exp[g] = dm; n_exp[g] = n;
        e0 = err_cnt[g]; v0 = vcnt[g];
        to = 0;
        while (!cmd_ready[g] && to < 1000) begin @(negedge clk); to++; end
        chk({tag, "_ready"}, 64'(cmd_ready[g]), 64'd1);
        cmd_byte[g] = c; rd_bits[g] = 6'(rd); dummy_clks[g] = 2'(dm); cmd_valid[g] = 1'b1;
        @(negedge clk);
        cmd_valid[g] = 1'b0;
        chk({tag, "_csx_low"}, 64'(csx[g]), 64'd0);
        to = 0;
        while (!rd_valid[g] && to < 3000) begin @(negedge clk); to++; end
        chk({tag, "_valid"}, 64'(rd_valid[g]), 64'd1);
        chk({tag, "_data"}, 64'(rd_data[g]), 64'(model(r, n)));
        chk({tag, "_rises"}, 64'(rises[g]), 64'(8 + dm + n));
        chk({tag, "_cmd"}, 64'(cmd_cap[g]), 64'(c));
        chk({tag, "_sdaread"}, 64'(err_cnt[g] - e0), 64'd0);
        chk({tag, "_end_pins"}, {62'd0, csx[g], sda_read[g]}, 64'd2);
        @(negedge clk);
        chk({tag, "_pulse"}, {62'd0, rd_valid[g], cmd_ready[g]}, 64'd1);
        chk({tag, "_vcnt"}, 64'(vcnt[g] - v0), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        logic [63:0] r;
        logic [31:0] held;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 1'b0; cmd_byte[g] = '0; rd_bits[g] = '0; dummy_clks[g] = '0;
            resp[g] = '0; d_exp[g] = 0; n_exp[g] = 0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_pins", {58'd0, csx[g], dc[g], sck[g], sda_out[g], sda_read[g], rd_valid[g]}, 64'h20);
            chk("rst_data", 64'(rd_data[g]), 64'd0);
            chk("rst_ready", {62'd0, cmd_ready[g], busy[g]}, 64'd2);
        end
        rst_n = 1'b1;
        @(negedge clk);

        xfer(0, 8'h04, 24, 1, {24'h7C89F0, 40'h0}, "t1");
        xfer(0, 8'h09, 32, 0, {32'hA5A5_0F0F, 32'h0}, "t2");
        held = rd_data[0];
        xfer(0, 8'h01, 0, 0, {$urandom, $urandom}, "t3");
        chk("t3_prev_nonzero", 64'(held), 64'hA5A5_0F0F);
        xfer(0, 8'hDA, 40, 2, {$urandom, $urandom}, "t4");

        for (int i = 0; i < 5; i++) begin
            xfer(0, 8'($urandom), $urandom_range(1, 40), $urandom_range(0, 3), {$urandom, $urandom}, "rnd0");
            xfer(1, 8'($urandom), $urandom_range(1, 40), $urandom_range(0, 3), {$urandom, $urandom}, "rnd1");
        end

        // T5: asynchronous reset in the middle of the read phase
        r = {$urandom, $urandom};
        resp[0] = r; d_exp[0] = 1; n_exp[0] = 32;
        cmd_byte[0] = 8'h0A; rd_bits[0] = 6'd32; dummy_clks[0] = 2'd1; cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        to = 0;
        while (rises[0] < 19 && to < 3000) begin @(negedge clk); to++; end
        chk("t5_reach_bit10", 64'(rises[0]), 64'd19);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_pins", {60'd0, csx[0], sck[0], sda_read[0], sda_out[0]}, 64'h8);
        chk("t5_async_ready", {61'd0, cmd_ready[0], busy[0], rd_valid[0]}, 64'h4);
        chk("t5_async_data", 64'(rd_data[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(0, 8'h04, 24, 1, {24'h5EC0DE, 40'h0}, "t5_after");

        // T6: request held high on the CLK_DIV=1 instance
        r = {$urandom, $urandom};
        resp[1] = r; d_exp[1] = 2; n_exp[1] = 16;
        cmd_byte[1] = 8'h09; rd_bits[1] = 6'd16; dummy_clks[1] = 2'd2; cmd_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to = 0;
            while (!rd_valid[1] && to < 1000) begin @(negedge clk); to++; end
            chk("t6_valid", 64'(rd_valid[1]), 64'd1);
            chk("t6_data", 64'(rd_data[1]), 64'(model(r, 16)));
            chk("t6_rises", 64'(rises[1]), 64'd26);
            if (i == 2) cmd_valid[1] = 1'b0;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("t6_idle", {62'd0, cmd_ready[1], csx[1]}, 64'd3);
        chk("t6_gap", 64'(gap_min[1] >= 1), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
